// File: rtl/pet_prg_loader.sv
// PRG stream loader for the PET: takes a 2-byte load address followed by payload
// bytes, DMA-writes the payload into RAM below DEST_LIMIT and optionally patches
// the BASIC end-of-program pointer once the stream ends.
module pet_prg_loader #(
  parameter logic [15:0] DEST_LIMIT  = 16'h8000,
  parameter logic [15:0] VARTAB_ADDR = 16'h002A,
  parameter bit          PATCH_PTR   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_start,
  input  logic        dl_valid,
  input  logic [7:0]  dl_data,
  input  logic        dl_last,
  output logic        dl_ready,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, ADDR_LO, ADDR_HI, DATA, PTR_LO, PTR_HI, FIN
  } state_t;

  state_t      state;
  logic [15:0] cur_addr;
  logic        accept;

  // Readiness is a pure decode of the state register.
  assign dl_ready = (state == ADDR_LO) || (state == ADDR_HI) || (state == DATA);
  assign accept   = dl_valid && dl_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cur_addr <= 16'h0000;
      dma_addr <= 16'h0000;
      dma_din  <= 8'h00;
      dma_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      dma_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (dl_start) begin
            state <= ADDR_LO;
            busy  <= 1'b1;
            error <= 1'b0;
          end
        end
        ADDR_LO: begin
          if (accept) begin
            cur_addr[7:0] <= dl_data;
            if (dl_last) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              state <= ADDR_HI;
            end
          end
        end
        ADDR_HI: begin
          if (accept) begin
            cur_addr[15:8] <= dl_data;
            if (dl_last) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            // Bytes aimed at or above the limit are swallowed and the address freezes.
            if (cur_addr < DEST_LIMIT) begin
              dma_we   <= 1'b1;
              dma_addr <= cur_addr;
              dma_din  <= dl_data;
              cur_addr <= cur_addr + 16'd1;
            end else begin
              error <= 1'b1;
            end
            if (dl_last) begin
              if (PATCH_PTR) begin
                state <= PTR_LO;
              end else begin
                done  <= 1'b1;
                state <= FIN;
              end
            end
          end
        end
        PTR_LO: begin
          dma_we   <= 1'b1;
          dma_addr <= VARTAB_ADDR;
          dma_din  <= cur_addr[7:0];
          state    <= PTR_HI;
        end
        PTR_HI: begin
          dma_we   <= 1'b1;
          dma_addr <= VARTAB_ADDR + 16'd1;
          dma_din  <= cur_addr[15:8];
          done     <= 1'b1;
          state    <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pet_prg_loader.sv
// Bench for pet_prg_loader: two instances (pointer patch on/off) share one stream
// driver; observed DMA writes are compared against a stream-level reference model.
module tb_pet_prg_loader;

  localparam logic [15:0] LIMIT  = 16'h8000;
  localparam logic [15:0] VARTAB = 16'h002A;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;
  typedef wr_t wq_t [$];

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dl_start, dl_valid, dl_last;
  logic [7:0]  dl_data;

  logic        dl_ready_a, dma_we_a, busy_a, done_a, error_a;
  logic [15:0] dma_addr_a;
  logic [7:0]  dma_din_a;
  logic        dl_ready_b, dma_we_b, busy_b, done_b, error_b;
  logic [15:0] dma_addr_b;
  logic [7:0]  dma_din_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  wq_t wq_a, wq_b;
  int  done_a_n, done_b_n, done_a_cyc, done_b_cyc;
  logic done_a_busy, done_b_busy;

  pet_prg_loader #(.DEST_LIMIT(LIMIT), .VARTAB_ADDR(VARTAB), .PATCH_PTR(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .dl_start(dl_start), .dl_valid(dl_valid),
    .dl_data(dl_data), .dl_last(dl_last), .dl_ready(dl_ready_a),
    .dma_addr(dma_addr_a), .dma_din(dma_din_a), .dma_we(dma_we_a),
    .busy(busy_a), .done(done_a), .error(error_a));

  pet_prg_loader #(.DEST_LIMIT(LIMIT), .VARTAB_ADDR(VARTAB), .PATCH_PTR(1'b0)) u_nop (
    .clk(clk), .reset_n(reset_n), .dl_start(dl_start), .dl_valid(dl_valid),
    .dl_data(dl_data), .dl_last(dl_last), .dl_ready(dl_ready_b),
    .dma_addr(dma_addr_b), .dma_din(dma_din_b), .dma_we(dma_we_b),
    .busy(busy_b), .done(done_b), .error(error_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dma_we_a === 1'b1) wq_a.push_back('{a: dma_addr_a, d: dma_din_a, c: cyc});
    if (dma_we_b === 1'b1) wq_b.push_back('{a: dma_addr_b, d: dma_din_b, c: cyc});
    if (done_a === 1'b1) begin done_a_n++; done_a_cyc = cyc; done_a_busy = busy_a; end
    if (done_b === 1'b1) begin done_b_n++; done_b_cyc = cyc; done_b_busy = busy_b; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp_writes(input string tag, input wq_t exp, input wq_t got);
    chk({tag, " write_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk($sformatf("%s w%0d addr", tag, i), got[i].a, exp[i].a);
      chk($sformatf("%s w%0d data", tag, i), got[i].d, exp[i].d);
      chk($sformatf("%s w%0d cycle", tag, i), got[i].c, exp[i].c);
    end
  endtask

  task automatic clear_mon();
    wq_a.delete(); wq_b.delete();
    done_a_n = 0; done_b_n = 0; done_a_cyc = -1; done_b_cyc = -1;
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk);
    dl_start = 1'b1;
    @(negedge clk);
    dl_start = 1'b0;
    chk({tag, " busy_after_start"}, busy_a, 1'b1);
    chk({tag, " error_cleared"}, error_a, 1'b0);
    chk({tag, " ready_after_start"}, dl_ready_a, 1'b1);
  endtask

  // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random valid
  task automatic run_stream(input bq_t s, input int mode, input bit inject_start, input string tag);
    int  acc[$];
    int  idx, guard, w, acc_last;
    bit  v, err;
    logic [15:0] a;
    wq_t exp_a, exp_b;
    pulse_start(tag);
    clear_mon();
    idx = 0; guard = 0;
    while (idx < s.size() && guard < 500) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = ($urandom_range(3) != 0);
      endcase
      dl_valid = v;
      dl_data  = v ? s[idx] : 8'($urandom);
      dl_last  = v ? (idx == s.size() - 1) : 1'($urandom);
      dl_start = inject_start && ($urandom_range(3) == 0);
      if (v && dl_ready_a) begin
        acc.push_back(cyc + 1);
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    dl_valid = 1'b0; dl_last = 1'b0; dl_start = 1'b0;
    chk({tag, " bytes_accepted"}, idx, s.size());
    w = 0;
    while ((done_a_n == 0 || done_b_n == 0) && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);

    acc_last = (acc.size() > 0) ? acc[acc.size() - 1] : 0;
    err = 1'b0;
    if (s.size() <= 2) begin
      err = 1'b1;
      chk({tag, " A done_cycle"}, done_a_cyc, acc_last);
    end else begin
      a = {s[1], s[0]};
      for (int i = 2; i < s.size(); i++) begin
        if (a < LIMIT) begin
          exp_a.push_back('{a: a, d: s[i], c: acc[i]});
          exp_b.push_back('{a: a, d: s[i], c: acc[i]});
          a = a + 16'd1;
        end else begin
          err = 1'b1;
        end
      end
      exp_a.push_back('{a: VARTAB,         d: a[7:0],  c: acc_last + 1});
      exp_a.push_back('{a: VARTAB + 16'd1, d: a[15:8], c: acc_last + 2});
      chk({tag, " A done_cycle"}, done_a_cyc, acc_last + 2);
    end
    chk({tag, " B done_cycle"}, done_b_cyc, acc_last);
    cmp_writes({tag, " A"}, exp_a, wq_a);
    cmp_writes({tag, " B"}, exp_b, wq_b);
    chk({tag, " A done_count"}, done_a_n, 1);
    chk({tag, " B done_count"}, done_b_n, 1);
    chk({tag, " A busy_at_done"}, done_a_busy, 1'b1);
    chk({tag, " B busy_at_done"}, done_b_busy, 1'b1);
    chk({tag, " A error"}, error_a, err);
    chk({tag, " B error"}, error_b, err);
    chk({tag, " A busy_end"}, busy_a, 1'b0);
    chk({tag, " B busy_end"}, busy_b, 1'b0);
    chk({tag, " A ready_end"}, dl_ready_a, 1'b0);
  endtask

  initial begin
    bq_t s;
    int  n, acc_n;
    logic [7:0] hi;
    reset_n = 1'b0; dl_start = 1'b0; dl_valid = 1'b0; dl_last = 1'b0; dl_data = 8'h00;
    clear_mon();
    #1;
    chk("reset dma_we", dma_we_a, 1'b0);
    chk("reset dma_addr", dma_addr_a, 16'h0000);
    chk("reset dma_din", dma_din_a, 8'h00);
    chk("reset ready", dl_ready_a, 1'b0);
    chk("reset busy", busy_a, 1'b0);
    chk("reset done", done_a, 1'b0);
    chk("reset error", error_a, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    s = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    run_stream(s, 0, 1'b0, "basic");
    s = '{8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33};
    run_stream(s, 0, 1'b0, "limit_edge");
    s = '{8'h01};
    run_stream(s, 0, 1'b0, "short_lo");
    s = '{8'h00, 8'h10, 8'h5A};
    run_stream(s, 0, 1'b0, "single");
    s = '{8'h01, 8'h02};
    run_stream(s, 2, 1'b0, "short_hi");
    s = '{8'h00, 8'h80, 8'h01, 8'h02};
    run_stream(s, 0, 1'b0, "load_at_limit");
    s = '{8'hFF, 8'hFF, 8'h05};
    run_stream(s, 1, 1'b0, "load_ffff");

    // Reset in the middle of a payload burst.
    pulse_start("rst");
    clear_mon();
    s = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h99};
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      dl_valid = 1'b1; dl_data = s[i]; dl_last = 1'b0;
      if (dl_ready_a) acc_n++;
      @(negedge clk);
    end
    dl_valid = 1'b0;
    chk("rst accepted_before", acc_n, 6);
    chk("rst we_before", dma_we_a, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst we_async", dma_we_a, 1'b0);
    chk("rst we_async_b", dma_we_b, 1'b0);
    chk("rst busy_async", busy_a, 1'b0);
    chk("rst addr_async", dma_addr_a, 16'h0000);
    chk("rst ready_async", dl_ready_a, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst no_done_a", done_a_n, 0);
    chk("rst no_done_b", done_b_n, 0);
    chk("rst busy_after", busy_a, 1'b0);

    s = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    run_stream(s, 0, 1'b0, "after_rst");

    s = '{8'h00, 8'h20};
    for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
    run_stream(s, 1, 1'b1, "toggle");

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(3))
        0:       hi = 8'h7F;
        1:       hi = 8'h80;
        2:       hi = 8'h10;
        default: hi = 8'($urandom);
      endcase
      s.delete();
      s.push_back(($urandom_range(1) == 0) ? 8'($urandom_range(8'hF0, 8'hFF)) : 8'($urandom));
      s.push_back(hi);
      n = ($urandom_range(5) == 0) ? $urandom_range(1) - 1 : $urandom_range(1, 12);
      if (n < 0) begin
        s.delete();
        s.push_back(8'($urandom));
      end else if (n > 0) begin
        for (int i = 0; i < n; i++) s.push_back(8'($urandom));
      end
      run_stream(s, 2, ($urandom_range(1) == 1), $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
